// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the register file with busy scoreboard.
package regfile_pkg;

    localparam int REGFILE_N_DEF      = 32;
    localparam int REGFILE_DEPTH_DEF  = 32;
    localparam int REGFILE_NUM_RD_DEF = 2;

    // Address width for a register file of the given depth (at least one bit).
    function automatic int regfile_addr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: set on issue, cleared on writeback.
// Register 0 is never busy. With REGFILE_BYPASS_EN defined, a read of a
// register that is being written in the same cycle reports not-busy unless
// the same register is also being re-issued.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH  = REGFILE_DEPTH_DEF,
    parameter int NUM_RD = REGFILE_NUM_RD_DEF,
    parameter int ADDR_W = regfile_addr_w(REGFILE_DEPTH_DEF)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic                     wr_ena0,
    input  logic [ADDR_W-1:0]        wr_addr0,
    input  logic                     wr_ena1,
    input  logic [ADDR_W-1:0]        wr_addr1,
    input  logic                     iss_ena,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic                     any_busy
);

    logic [DEPTH-1:0] busy_reg;
    logic [DEPTH-1:0] set_vec;
    logic [DEPTH-1:0] clr_vec;
    logic [DEPTH-1:0] busy_next;

    // Entry 0 can never be set or cleared; it stays at its reset value of 0.
    assign set_vec[0] = 1'b0;
    assign clr_vec[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_decode
            assign set_vec[gi] = iss_ena && (iss_addr == ADDR_W'(gi));
            assign clr_vec[gi] = (wr_ena0 && (wr_addr0 == ADDR_W'(gi)))
                              || (wr_ena1 && (wr_addr1 == ADDR_W'(gi)));
        end
    endgenerate

    // Set dominates clear so a same-cycle re-issue keeps the register busy.
    always_comb begin
        busy_next = (busy_reg & ~clr_vec) | set_vec;
    end

    // Busy flops; reset discards every pending producer.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign any_busy = |busy_reg;

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic              in_range;
            assign addr     = rd_addr[gi*ADDR_W +: ADDR_W];
            assign in_range = (addr != '0) && (int'(addr) < DEPTH);

            // Busy lookup for read port gi; zero/out-of-range reads are never busy.
            always_comb begin
                rd_busy[gi] = 1'b0;
                if (in_range) begin
                    rd_busy[gi] = busy_reg[addr];
`ifdef REGFILE_BYPASS_EN
                    if (((wr_ena0 && wr_addr0 == addr) || (wr_ena1 && wr_addr1 == addr))
                        && !(iss_ena && iss_addr == addr)) begin
                        rd_busy[gi] = 1'b0;
                    end
`endif
                end
            end
        end
    endgenerate

endmodule

// File: rtl/register_file_sb.sv
// Multi-port register file (NUM_RD async reads, two writes) with a busy
// scoreboard for RAW stall detection. r0 reads zero and is never busy.
// Optional macro REGFILE_BYPASS_EN: same-cycle write data is forwarded to
// matching read ports (write port 1 has priority).
module register_file_sb
    import regfile_pkg::*;
#(
    parameter int N      = REGFILE_N_DEF,
    parameter int DEPTH  = REGFILE_DEPTH_DEF,
    parameter int NUM_RD = REGFILE_NUM_RD_DEF,
    localparam int ADDR_W = regfile_addr_w(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*N-1:0]      rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_ena0,
    input  logic [ADDR_W-1:0]        wr_addr0,
    input  logic [N-1:0]             wr_data0,
    input  logic                     wr_ena1,
    input  logic [ADDR_W-1:0]        wr_addr1,
    input  logic [N-1:0]             wr_data1,
    input  logic                     iss_ena,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     any_busy
);

    logic [N-1:0]     regs_reg [DEPTH];
    logic [DEPTH-1:0] wr0_hit;
    logic [DEPTH-1:0] wr1_hit;

    // Address 0 is hardwired to zero, so it never decodes as a write target.
    assign wr0_hit[0] = 1'b0;
    assign wr1_hit[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_wdec
            assign wr0_hit[gi] = wr_ena0 && (wr_addr0 == ADDR_W'(gi));
            assign wr1_hit[gi] = wr_ena1 && (wr_addr1 == ADDR_W'(gi));
        end
    endgenerate

    // Data storage; port 1 overrides port 0 when both target the same entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (wr1_hit[i]) begin
                    regs_reg[i] <= wr_data1;
                end else if (wr0_hit[i]) begin
                    regs_reg[i] <= wr_data0;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic              in_range;
            assign addr     = rd_addr[gi*ADDR_W +: ADDR_W];
            assign in_range = (addr != '0) && (int'(addr) < DEPTH);

            // Combinational read for port gi, with optional write-through.
            always_comb begin
                rd_data[gi*N +: N] = '0;
                if (in_range) begin
                    rd_data[gi*N +: N] = regs_reg[addr];
`ifdef REGFILE_BYPASS_EN
                    if (wr_ena1 && wr_addr1 == addr) begin
                        rd_data[gi*N +: N] = wr_data1;
                    end else if (wr_ena0 && wr_addr0 == addr) begin
                        rd_data[gi*N +: N] = wr_data0;
                    end
`endif
                end
            end
        end
    endgenerate

    regfile_scoreboard #(
        .DEPTH  (DEPTH),
        .NUM_RD (NUM_RD),
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .wr_ena0  (wr_ena0),
        .wr_addr0 (wr_addr0),
        .wr_ena1  (wr_ena1),
        .wr_addr1 (wr_addr1),
        .iss_ena  (iss_ena),
        .iss_addr (iss_addr),
        .rd_busy  (rd_busy),
        .any_busy (any_busy)
    );

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb (default parameters). A behavioural model of the
// register contents and busy set is checked against the DUT every negedge,
// and directed steps add literal expectations.
module tb_register_file_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr_ena0, wr_ena1, iss_ena;
    logic [4:0]  wr_addr0, wr_addr1, iss_addr;
    logic [31:0] wr_data0, wr_data1;
    logic        any_busy;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_regs [32];
    bit          m_busy [32];

    always #5 clk = ~clk;

    register_file_sb dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_ena0  (wr_ena0),
        .wr_addr0 (wr_addr0),
        .wr_data0 (wr_data0),
        .wr_ena1  (wr_ena1),
        .wr_addr1 (wr_addr1),
        .wr_data1 (wr_data1),
        .iss_ena  (iss_ena),
        .iss_addr (iss_addr),
        .any_busy (any_busy)
    );

    // Model state update following the register/busy rules.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'd0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (wr_ena0 && wr_addr0 != 0 && !(wr_ena1 && wr_addr1 == wr_addr0)) begin
                m_regs[wr_addr0] = wr_data0;
                m_busy[wr_addr0] = 1'b0;
            end
            if (wr_ena1 && wr_addr1 != 0) begin
                m_regs[wr_addr1] = wr_data1;
                m_busy[wr_addr1] = 1'b0;
            end
            if (iss_ena && iss_addr != 0) m_busy[iss_addr] = 1'b1;
        end
    end

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (a == 0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (wr_ena1 && wr_addr1 == a) return wr_data1;
        if (wr_ena0 && wr_addr0 == a) return wr_data0;
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (((wr_ena0 && wr_addr0 == a) || (wr_ena1 && wr_addr1 == a))
            && !(iss_ena && iss_addr == a)) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    function automatic logic exp_any();
        logic r = 1'b0;
        for (int i = 0; i < 32; i++) r |= m_busy[i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("cyc_data%0d@%0d", k, rd_addr[k*5 +: 5]),
                    rd_data[k*32 +: 32], exp_data(rd_addr[k*5 +: 5]));
                chk($sformatf("cyc_busy%0d@%0d", k, rd_addr[k*5 +: 5]),
                    {31'd0, rd_busy[k]}, {31'd0, exp_busy(rd_addr[k*5 +: 5])});
            end
            chk("cyc_any", {31'd0, any_busy}, {31'd0, exp_any()});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_ena0 = 1'b0; wr_ena1 = 1'b0; iss_ena = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
        #2;
    endtask

    initial begin
        rst = 1'b1; rd_addr = '0; idle();
        wr_addr0 = '0; wr_addr1 = '0; iss_addr = '0; wr_data0 = '0; wr_data1 = '0;
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;

        // 1: everything reads zero after reset
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 5'(31 - i));
            chk("rst_data0", rd_data[31:0], 32'd0);
            chk("rst_data1", rd_data[63:32], 32'd0);
            chk("rst_busy", {30'd0, rd_busy}, 32'd0);
            chk("rst_any", {31'd0, any_busy}, 32'd0);
        end
        $display("txn reset-scan done");

        // 2: fill through port 0 (includes an ignored write of 17 to r0)
        for (int i = 0; i < 32; i++) begin
            wr_ena0 = 1'b1; wr_addr0 = 5'(i); wr_data0 = 32'((i + 1) * 17);
            step();
        end
        idle();
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 5'(31 - i));
            chk("fill_p0", rd_data[31:0], (i == 0) ? 32'd0 : 32'((i + 1) * 17));
            chk("fill_p1", rd_data[63:32], (i == 31) ? 32'd0 : 32'((32 - i) * 17));
        end
        rd(5'd1, 5'd31);
        chk("lit_r1", rd_data[31:0], 32'd34);
        chk("lit_r31", rd_data[63:32], 32'd544);
        $display("txn fill done");

        // 3: dual-write collision and independent dual write
        wr_ena0 = 1'b1; wr_addr0 = 5'd5; wr_data0 = 32'hAAAA;
        wr_ena1 = 1'b1; wr_addr1 = 5'd5; wr_data1 = 32'h5555;
        step();
        wr_addr0 = 5'd6; wr_data0 = 32'd1; wr_addr1 = 5'd7; wr_data1 = 32'd2;
        step();
        idle();
        rd(5'd5, 5'd6);
        chk("coll_r5", rd_data[31:0], 32'h5555);
        chk("dual_r6", rd_data[63:32], 32'd1);
        rd(5'd7, 5'd0);
        chk("dual_r7", rd_data[31:0], 32'd2);
        $display("txn dual-write r5=%h", dut.regs_reg[5]);

        // 4: issue / writeback / issue+write
        iss_ena = 1'b1; iss_addr = 5'd9;
        step(); idle();
        rd(5'd9, 5'd8);
        chk("iss_busy9", {31'd0, rd_busy[0]}, 32'd1);
        chk("iss_busy8", {31'd0, rd_busy[1]}, 32'd0);
        chk("iss_any", {31'd0, any_busy}, 32'd1);
        wr_ena1 = 1'b1; wr_addr1 = 5'd9; wr_data1 = 32'h0BAD;
        step(); idle();
        rd(5'd9, 5'd9);
        chk("wb_busy9", {31'd0, rd_busy[1]}, 32'd0);
        chk("wb_any", {31'd0, any_busy}, 32'd0);
        chk("wb_r9", rd_data[63:32], 32'h0BAD);
        iss_ena = 1'b1; iss_addr = 5'd9;
        wr_ena0 = 1'b1; wr_addr0 = 5'd9; wr_data0 = 32'h1234;
        step(); idle();
        rd(5'd9, 5'd0);
        chk("isswr_busy", {31'd0, rd_busy[0]}, 32'd1);
        chk("isswr_r9", rd_data[31:0], 32'h1234);
        $display("txn scoreboard r9 busy=%0d", rd_busy[0]);

        // 6: same-cycle read of a register being written (r4 holds 85)
        rd_addr = {5'd0, 5'd4};
        wr_ena0 = 1'b1; wr_addr0 = 5'd4; wr_data0 = 32'hDEAD;
        #2;
`ifdef REGFILE_BYPASS_EN
        chk("byp_same", rd_data[31:0], 32'hDEAD);
`else
        chk("byp_same", rd_data[31:0], 32'd85);
`endif
        step(); idle();
        rd(5'd4, 5'd0);
        chk("byp_next", rd_data[31:0], 32'hDEAD);
        // read of busy r9 during its writeback
        rd_addr = {5'd9, 5'd0};
        wr_ena1 = 1'b1; wr_addr1 = 5'd9; wr_data1 = 32'h7;
        #2;
`ifdef REGFILE_BYPASS_EN
        chk("byp_busy", {31'd0, rd_busy[1]}, 32'd0);
`else
        chk("byp_busy", {31'd0, rd_busy[1]}, 32'd1);
`endif
        step(); idle();
        $display("txn bypass r4=%h", rd_data[31:0]);

        // 5: reset while busy, then issue to r0
        iss_ena = 1'b1; iss_addr = 5'd3;
        step(); idle();
        rd(5'd3, 5'd2);
        chk("pre_rst_busy3", {31'd0, rd_busy[0]}, 32'd1);
        rst = 1'b1;
        wr_ena0 = 1'b1; wr_addr0 = 5'd2; wr_data0 = 32'hFFFF;
        step(); idle(); rst = 1'b0;
        rd(5'd3, 5'd2);
        chk("rst_busy3", {31'd0, rd_busy[0]}, 32'd0);
        chk("rst_r3", rd_data[31:0], 32'd0);
        chk("rst_r2", rd_data[63:32], 32'd0);
        chk("rst_any2", {31'd0, any_busy}, 32'd0);
        iss_ena = 1'b1; iss_addr = 5'd0;
        step(); idle();
        rd(5'd0, 5'd0);
        chk("iss0_busy", {31'd0, rd_busy[0]}, 32'd0);
        chk("iss0_any", {31'd0, any_busy}, 32'd0);
        $display("txn reset-midstream any_busy=%0d", any_busy);

        step();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
